uart_reg_writer: RTL and testbench

//  UART command receiver that drives the register-write bus (data/addr/en) feeding the interrupter storage registers.

---
 rtl/uart_reg_writer_pkg.sv | 25 ++
 rtl/uart_reg_writer_rx.sv | 97 +++++++++
 rtl/uart_reg_writer.sv | 123 ++++++++++++
 tb/tb_uart_reg_writer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_reg_writer_pkg.sv
// Shared types and constants for the UART register-write command path.
package uart_reg_writer_pkg;

    localparam int unsigned FRAME_LEN = 4;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    typedef enum logic [$clog2(FRAME_LEN)-1:0] {
        S_SYNC,
        S_ADDR,
        S_DATA,
        S_CHK
    } frame_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rx_state_t;

    function automatic logic [7:0] frame_sum(input logic [7:0] a, input logic [7:0] d);
        return a + d;
    endfunction

endpackage

// File: rtl/uart_reg_writer_rx.sv
// 8N1 UART byte receiver: 2-FF synchronizer, mid-bit sampling, LSB-first shift register.
module uart_rx_byte
    import uart_reg_writer_pkg::*;
#(
    parameter int unsigned BIT_DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned CW = $clog2(BIT_DIV);
    localparam logic [CW-1:0] CNT_FULL = CW'(BIT_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BIT_DIV / 2 - 1);

    rx_state_t     state, state_n;
    logic          rx_meta, rx_sync, rx_prev;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic          shift_en, done_ok, done_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            byte_valid <= done_ok;
            frame_err  <= done_bad;
            if (shift_en) begin
                rx_byte <= {rx_sync, rx_byte[7:1]};
            end
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CW'(1);
        bit_idx_n = bit_idx;
        shift_en  = 1'b0;
        done_ok   = 1'b0;
        done_bad  = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_n = '0;
                if (rx_prev && !rx_sync) begin
                    state_n = RX_START;
                end
            end
            RX_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    // A start bit that reads high at mid-bit was a glitch: drop it silently.
                    state_n   = rx_sync ? RX_IDLE : RX_BITS;
                end
            end
            RX_BITS: begin
                if (cnt == CNT_FULL) begin
                    cnt_n     = '0;
                    shift_en  = 1'b1;
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt == CNT_FULL) begin
                    cnt_n    = '0;
                    done_ok  = rx_sync;
                    done_bad = !rx_sync;
                    state_n  = RX_IDLE;
                end
            end
            default: begin
                state_n = RX_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_reg_writer.sv
// Frame decoder turning {SYNC, addr, data, chk} UART frames into one-cycle register write strobes.
module uart_reg_writer
    import uart_reg_writer_pkg::*;
#(
    parameter int unsigned CLK_MHZ     = 100,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned PAR_MAX_VAL = 255,
    parameter int unsigned ADDR_MAX    = 4,
    parameter int unsigned TIMEOUT_US  = 1000
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               rx,
    output logic [$clog2(PAR_MAX_VAL+1)-1:0]   data,
    output logic [$clog2(ADDR_MAX+1)-1:0]      addr,
    output logic                               en,
    output logic                               err,
    output logic                               busy
);

    localparam int unsigned BIT_DIV = CLK_MHZ * 1_000_000 / BAUD;
    localparam int unsigned TO_CYC  = TIMEOUT_US * CLK_MHZ;
    localparam int unsigned TO_W    = $clog2(TO_CYC + 1);
    localparam int unsigned DW      = $clog2(PAR_MAX_VAL + 1);
    localparam int unsigned AW      = $clog2(ADDR_MAX + 1);
    localparam logic [7:0]  ADDR_LIM = 8'(ADDR_MAX);
    localparam logic [7:0]  DATA_LIM = 8'(PAR_MAX_VAL);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

    frame_state_t    state, state_n;
    logic [7:0]      rx_byte;
    logic            byte_valid, frame_err;
    logic [7:0]      addr_tmp, data_tmp;
    logic [TO_W-1:0] to_cnt;
    logic            timeout, chk_ok;
    logic            take_addr, take_data, commit, err_n;

    uart_rx_byte #(
        .BIT_DIV(BIT_DIV)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    assign busy    = (state != S_SYNC);
    assign timeout = busy && (to_cnt == TO_LAST);
    assign chk_ok  = (rx_byte == frame_sum(addr_tmp, data_tmp))
                  && (addr_tmp <= ADDR_LIM) && (data_tmp <= DATA_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_SYNC;
            addr_tmp <= '0;
            data_tmp <= '0;
            to_cnt   <= '0;
            addr     <= '0;
            data     <= '0;
            en       <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_n;
            en    <= commit;
            err   <= err_n;
            if (take_addr) begin
                addr_tmp <= rx_byte;
            end
            if (take_data) begin
                data_tmp <= rx_byte;
            end
            if (commit) begin
                addr <= addr_tmp[AW-1:0];
                data <= data_tmp[DW-1:0];
            end
            if (byte_valid || !busy) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    // byte_valid takes priority over a coincident timeout; a framing error yields one err pulse.
    always_comb begin
        state_n   = state;
        take_addr = 1'b0;
        take_data = 1'b0;
        commit    = 1'b0;
        err_n     = frame_err;
        if (byte_valid) begin
            case (state)
                S_SYNC: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_n = S_ADDR;
                    end
                end
                S_ADDR: begin
                    take_addr = 1'b1;
                    state_n   = S_DATA;
                end
                S_DATA: begin
                    take_data = 1'b1;
                    state_n   = S_CHK;
                end
                S_CHK: begin
                    commit  = chk_ok;
                    err_n   = !chk_ok;
                    state_n = S_SYNC;
                end
                default: begin
                    state_n = S_SYNC;
                end
            endcase
        end else if (frame_err || timeout) begin
            err_n   = 1'b1;
            state_n = S_SYNC;
        end
    end

endmodule

// File: tb/tb_uart_reg_writer.sv
// Scoreboard bench for uart_reg_writer: stimulus pushes expected en/err events, a monitor pops them.
module tb_uart_reg_writer;

    localparam int BIT_T = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic [2:0] addr;
    logic       en, err, busy;

    typedef struct {
        bit         is_en;
        logic [2:0] addr;
        logic [7:0] data;
        longint     tmin;
        longint     tmax;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail = 0;
    longint     t_ref = 0;
    logic [2:0] last_addr = '0;
    logic [7:0] last_data = '0;

    always #5 clk = ~clk;

    uart_reg_writer #(
        .CLK_MHZ    (100),
        .BAUD       (1_000_000),
        .PAR_MAX_VAL(255),
        .ADDR_MAX   (4),
        .TIMEOUT_US (50)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (rx),
        .data (data),
        .addr (addr),
        .en   (en),
        .err  (err),
        .busy (busy)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected within [%0d,%0d] (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    task automatic expect_ev(input bit is_en, input logic [2:0] a, input logic [7:0] d,
                             input longint lo, input longint hi);
        exp_t e;
        e.is_en = is_en;
        e.addr  = a;
        e.data  = d;
        e.tmin  = lo;
        e.tmax  = hi;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_bit);
        t_ref = longint'($time);
        rx = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(BIT_T);
        end
        rx = stop_bit;
        #(BIT_T);
        rx = 1'b1;
    endtask

    task automatic send4(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        @(negedge clk);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        send_byte(b3, 1'b1);
        #(2 * BIT_T);
    endtask

    // Monitor: every en/err pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_addr = addr;
            last_data = data;
        end else begin
            if (en || err) begin
                check("en_err_exclusive", longint'(en && err), 0);
            end
            if (addr !== last_addr || data !== last_data) begin
                check("outputs_change_only_on_en", longint'(en), 1);
            end
            last_addr = addr;
            last_data = data;
            if (en || err) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: en=%0b err=%0b with nothing expected (t=%0t)",
                             en, err, $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("event_is_en", longint'(en), longint'(mon_e.is_en));
                    check("addr", longint'(addr), longint'(mon_e.addr));
                    check("data", longint'(data), longint'(mon_e.data));
                    check_range("event_latency", longint'($time) - t_ref, mon_e.tmin, mon_e.tmax);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_data", longint'(data), 0);
        check("reset_addr", longint'(addr), 0);
        check("reset_en", longint'(en), 0);
        check("reset_err", longint'(err), 0);
        check("reset_busy", longint'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Good frame: en one cycle after the checksum stop-bit sample (~9.5 bit times).
        expect_ev(1'b1, 3'd3, 8'h40, 9500, 9700);
        send4(8'hA5, 8'h03, 8'h40, 8'h43);

        // Bad checksum.
        expect_ev(1'b0, 3'd3, 8'h40, 9500, 9700);
        send4(8'hA5, 8'h03, 8'h40, 8'h44);

        // Address above ADDR_MAX, consistent checksum.
        expect_ev(1'b0, 3'd3, 8'h40, 9500, 9700);
        send4(8'hA5, 8'h07, 8'h10, 8'h17);

        // Address one above the limit.
        expect_ev(1'b0, 3'd3, 8'h40, 9500, 9700);
        send4(8'hA5, 8'h05, 8'h00, 8'h05);

        // Garbage then frame, all back-to-back.
        expect_ev(1'b1, 3'd1, 8'h22, 9500, 9700);
        @(negedge clk);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h23, 1'b1);
        #(2 * BIT_T);

        // Timeout: err 50 us after the last byte's stop sample.
        expect_ev(1'b0, 3'd1, 8'h22, 59500, 60500);
        @(negedge clk);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        check("busy_mid_frame", longint'(busy), 1);
        #(60000);
        check("busy_after_timeout", longint'(busy), 0);

        expect_ev(1'b1, 3'd2, 8'h55, 9500, 9700);
        send4(8'hA5, 8'h02, 8'h55, 8'h57);

        // Framing error on the data byte.
        expect_ev(1'b0, 3'd2, 8'h55, 9500, 9700);
        @(negedge clk);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h33, 1'b0);
        #(2 * BIT_T);
        check("busy_after_framing_err", longint'(busy), 0);

        // Reset mid-frame.
        @(negedge clk);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        check("busy_before_reset", longint'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("midreset_data", longint'(data), 0);
        check("midreset_addr", longint'(addr), 0);
        check("midreset_en", longint'(en), 0);
        check("midreset_err", longint'(err), 0);
        check("midreset_busy", longint'(busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Without SYNC these bytes are ignored; then a frame at ADDR_MAX.
        @(negedge clk);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        #(2 * BIT_T);
        expect_ev(1'b1, 3'd4, 8'h10, 9500, 9700);
        send4(8'hA5, 8'h04, 8'h10, 8'h14);

        for (int i = 0; i < 20000 && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        check("scoreboard_drained", longint'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
